// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port integer register file.
package regfile_pkg;

  typedef enum logic [1:0] {RF_IDLE, RF_CLEAR, RF_DONE} rf_clr_state_e;

  localparam int RF_ZERO_REG = 0;

endpackage

// File: rtl/regfile_wr_sel.sv
// Priority select of one address over all write ports; the highest-index hit wins.
// Used both for per-register write decode and for the optional read bypass.
module regfile_wr_sel #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_WR = 2
) (
  input  logic [ADDR_W-1:0]        match_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     we,
  output logic [DATA_W-1:0]        data
);

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    we   = 1'b0;
    data = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == match_addr)) begin
        we   = 1'b1;
        data = wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with pending scoreboard and sequenced bulk clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ADDR_W   = $clog2(NUM_REGS)  // derived; do not override
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_pend_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic                     alloc_en_i,
  input  logic [ADDR_W-1:0]        alloc_addr_i,
  input  logic                     clr_req_i,
  output logic                     clr_busy_o,
  output logic                     clr_done_o
);

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  rf_clr_state_e     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              idle;
  logic [NUM_WR-1:0] wr_en_g;
  logic              alloc_g;

  assign idle       = (state_q == RF_IDLE);
  assign wr_en_g    = wr_en_i & {NUM_WR{idle}};
  assign alloc_g    = alloc_en_i & idle;
  assign clr_busy_o = !idle;
  assign clr_done_o = (state_q == RF_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RF_IDLE: begin
        if (clr_req_i) begin
          state_d = RF_CLEAR;
          cnt_d   = ADDR_W'(1);
        end
      end
      RF_CLEAR: begin
        if (cnt_q == LAST_REG) state_d = RF_DONE;
        else                   cnt_d   = cnt_q + ADDR_W'(1);
      end
      RF_DONE: state_d = RF_IDLE;
      default: state_d = RF_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write decode for registers 1..NUM_REGS-1; the zero register never sees a write.
  logic [NUM_REGS-1:0]             reg_we;
  logic [NUM_REGS-1:0][DATA_W-1:0] reg_wdata;

  assign reg_we[RF_ZERO_REG]    = 1'b0;
  assign reg_wdata[RF_ZERO_REG] = '0;

  for (genvar i = RF_ZERO_REG + 1; i < NUM_REGS; i++) begin : g_wsel
    regfile_wr_sel #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_wr_sel (
      .match_addr (ADDR_W'(i)),
      .wr_en      (wr_en_g),
      .wr_addr    (wr_addr_i),
      .wr_data    (wr_data_i),
      .we         (reg_we[i]),
      .data       (reg_wdata[i])
    );
  end

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pend;

  // NOTE: the file is flop-based and must read as zero after reset, so every entry is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pend <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if ((state_q == RF_CLEAR) && (cnt_q == ADDR_W'(i))) begin
          regs[i] <= '0;
          pend[i] <= 1'b0;
        end else begin
          if (reg_we[i]) regs[i] <= reg_wdata[i];
          // A new producer outranks the write retiring in the same cycle.
          if (alloc_g && (alloc_addr_i == ADDR_W'(i))) pend[i] <= 1'b1;
          else if (reg_we[i])                          pend[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              rd_ok;
    logic [DATA_W-1:0] st_data;
    logic              st_pend;

    assign ra      = rd_addr_i[p*ADDR_W +: ADDR_W];
    assign rd_ok   = (int'(ra) < NUM_REGS) && (ra != ADDR_W'(RF_ZERO_REG));
    assign st_data = rd_ok ? regs[ra] : '0;
    assign st_pend = rd_ok ? pend[ra] : 1'b0;

`ifdef REGFILE_BYPASS_EN
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;

    regfile_wr_sel #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_byp_sel (
      .match_addr (ra),
      .wr_en      (wr_en_g),
      .wr_addr    (wr_addr_i),
      .wr_data    (wr_data_i),
      .we         (byp_hit),
      .data       (byp_data)
    );

    assign rd_data_o[p*DATA_W +: DATA_W] = (rd_ok && byp_hit) ? byp_data : st_data;
    assign rd_pend_o[p] = (rd_ok && byp_hit) ? (alloc_g && (alloc_addr_i == ra)) : st_pend;
`else
    assign rd_data_o[p*DATA_W +: DATA_W] = st_data;
    assign rd_pend_o[p]                  = st_pend;
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expectations, a negedge monitor checks them.
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW  = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_pend;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              alloc_en;
  logic [AW-1:0]     alloc_addr;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W   (DW),
    .NUM_REGS (NR),
    .NUM_RD   (NRD),
    .NUM_WR   (NWR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .rd_pend_o    (rd_pend),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .alloc_en_i   (alloc_en),
    .alloc_addr_i (alloc_addr),
    .clr_req_i    (clr_req),
    .clr_busy_o   (clr_busy),
    .clr_done_o   (clr_done)
  );

  typedef enum {K_DATA, K_PEND, K_BUSY, K_DONE} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    int          port;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       tests_run = 0;
  int       failures  = 0;
  logic     chk_strobe = 1'b0;

  sb_item_t    mon_item;
  logic [31:0] mon_act;

  always @(negedge clk) begin : monitor
    if (chk_strobe) begin
      while (sb_q.size() > 0) begin
        mon_item = sb_q.pop_front();
        case (mon_item.kind)
          K_DATA:  mon_act = rd_data[mon_item.port*DW +: DW];
          K_PEND:  mon_act = {31'b0, rd_pend[mon_item.port]};
          K_BUSY:  mon_act = {31'b0, clr_busy};
          default: mon_act = {31'b0, clr_done};
        endcase
        tests_run++;
        if (mon_act !== mon_item.exp) begin
          failures++;
          $display("FAIL %s (port %0d kind %s): actual %h required %h",
                   mon_item.name, mon_item.port, mon_item.kind.name(), mon_act, mon_item.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
    chk_strobe = 1'b0;
  endtask

  task automatic quiet();
    wr_en    = '0;
    alloc_en = 1'b0;
    clr_req  = 1'b0;
  endtask

  task automatic drive_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[k]             = 1'b1;
    wr_addr[k*AW +: AW]  = a;
    wr_data[k*DW +: DW]  = d;
  endtask

  task automatic expect_rd(input string nm, input int p, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic pd);
    rd_addr[p*AW +: AW] = a;
    sb_q.push_back('{name: nm, kind: K_DATA, port: p, exp: d});
    sb_q.push_back('{name: nm, kind: K_PEND, port: p, exp: {31'b0, pd}});
    chk_strobe = 1'b1;
  endtask

  task automatic expect_flag(input string nm, input kind_e k, input logic v);
    sb_q.push_back('{name: nm, kind: k, port: 0, exp: {31'b0, v}});
    chk_strobe = 1'b1;
  endtask

  initial begin : stimulus
    rst        = 1'b1;
    rd_addr    = '0;
    wr_addr    = '0;
    wr_data    = '0;
    alloc_addr = '0;
    quiet();
    step();
    step();
    rst = 1'b0;

    // T1: every address reads zero / not pending after reset
    for (int a = 0; a < NR; a++) begin
      expect_rd("t1_rd0", 0, AW'(a), 32'h0, 1'b0);
      expect_rd("t1_rd1", 1, AW'(NR - 1 - a), 32'h0, 1'b0);
      expect_flag("t1_busy", K_BUSY, 1'b0);
      expect_flag("t1_done", K_DONE, 1'b0);
      step();
    end

    // T2: same-address writes, higher port wins; distinct addresses both land
    drive_wr(0, 5'd5, 32'h11);
    drive_wr(1, 5'd5, 32'h22);
    step();
    quiet();
    expect_rd("t2_x5_prio", 0, 5'd5, 32'h22, 1'b0);
    step();
    drive_wr(0, 5'd6, 32'h66);
    drive_wr(1, 5'd9, 32'h99);
    step();
    quiet();
    expect_rd("t2_x6", 0, 5'd6, 32'h66, 1'b0);
    expect_rd("t2_x9", 1, 5'd9, 32'h99, 1'b0);
    step();

    // T3: alloc sets pend; alloc beats a same-cycle write; plain write clears pend
    alloc_en   = 1'b1;
    alloc_addr = 5'd7;
    step();
    quiet();
    expect_rd("t3_alloc", 0, 5'd7, 32'h0, 1'b1);
    step();
    drive_wr(0, 5'd7, 32'hAB);
    alloc_en   = 1'b1;
    alloc_addr = 5'd7;
    step();
    quiet();
    expect_rd("t3_wr_alloc", 0, 5'd7, 32'hAB, 1'b1);
    step();
    drive_wr(1, 5'd7, 32'hCD);
    step();
    quiet();
    expect_rd("t3_wr_only", 0, 5'd7, 32'hCD, 1'b0);
    step();

    // T4: writes and allocs to x0 are dropped, also in the issuing cycle
    drive_wr(1, 5'd0, 32'hFFFF_FFFF);
    alloc_en   = 1'b1;
    alloc_addr = 5'd0;
    expect_rd("t4_x0_same", 0, 5'd0, 32'h0, 1'b0);
    step();
    quiet();
    expect_rd("t4_x0_next", 0, 5'd0, 32'h0, 1'b0);
    step();

    // T6a: same-cycle read of a register being written (bypass-dependent)
    drive_wr(0, 5'd3, 32'h33);
    step();
    quiet();
    alloc_en   = 1'b1;
    alloc_addr = 5'd3;
    step();
    quiet();
    expect_rd("t6_pre", 1, 5'd3, 32'h33, 1'b1);
    step();
    drive_wr(0, 5'd3, 32'h5A);
    expect_rd("t6_same_cycle", 1, 5'd3, BYP ? 32'h5A : 32'h33, BYP ? 1'b0 : 1'b1);
    step();
    quiet();
    expect_rd("t6_after", 1, 5'd3, 32'h5A, 1'b0);
    step();

    // T5: fill x1..x31, then bulk clear with writes/allocs attempted while busy
    for (int i = 1; i < NR; i += 2) begin
      drive_wr(0, AW'(i), 32'h100 + 32'(i));
      if (i + 1 < NR) drive_wr(1, AW'(i + 1), 32'h100 + 32'(i + 1));
      step();
      quiet();
    end
    expect_rd("t5_fill_x1", 0, 5'd1, 32'h101, 1'b0);
    expect_rd("t5_fill_x31", 1, 5'd31, 32'h11F, 1'b0);
    clr_req = 1'b1;
    expect_flag("t5_busy_c0", K_BUSY, 1'b0);
    step();
    clr_req = 1'b0;
    for (int c = 1; c <= NR; c++) begin
      drive_wr(0, 5'd5, 32'hDEAD);
      alloc_en   = 1'b1;
      alloc_addr = 5'd9;
      expect_flag("t5_busy", K_BUSY, 1'b1);
      expect_flag("t5_done", K_DONE, c == NR);
      expect_rd("t5_rd_x31", 1, 5'd31, (c <= NR - 1) ? 32'h11F : 32'h0, 1'b0);
      step();
    end
    quiet();
    expect_flag("t5_busy_end", K_BUSY, 1'b0);
    expect_flag("t5_done_end", K_DONE, 1'b0);
    step();
    for (int a = 1; a < NR; a += 2) begin
      expect_rd("t5_zero0", 0, AW'(a), 32'h0, 1'b0);
      expect_rd("t5_zero1", 1, AW'(a + 1), 32'h0, 1'b0);
      step();
    end
    drive_wr(0, 5'd5, 32'h55);
    step();
    quiet();
    expect_rd("t5_resume", 0, 5'd5, 32'h55, 1'b0);
    step();

    // T6b: synchronous reset in cycle 10 of a clear aborts with no done pulse
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 1; c < 10; c++) step();
    expect_flag("t6_busy_c10", K_BUSY, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_flag("t6_busy_rst", K_BUSY, 1'b0);
    expect_flag("t6_done_rst", K_DONE, 1'b0);
    expect_rd("t6_x5_rst", 0, 5'd5, 32'h0, 1'b0);
    step();
    for (int c = 0; c < NR + 2; c++) begin
      expect_flag("t6_no_done", K_DONE, 1'b0);
      expect_flag("t6_idle", K_BUSY, 1'b0);
      step();
    end

    step();
    tests_run++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: actual %0d pending entries required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
